mem_bus_arbiter: RTL and testbench

- Shares one downstream memory port (lock/rqst/trsc/addr out; resp/mesi in) between NREQ upstream requesters that use the same port protocol.
- Sits between the cores/caches and the memory-side slave, such as the bus terminator or the L2.
- Arbitration is round-robin, with one outstanding transaction at a time.
- Supports bus locking for atomic multi-transaction sequences.
- Routes each response back to the requester that was granted.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of upstream requester ports, the shared downstream memory port and
// arbiter status, as seen by the arbiter (master) and its environment (slave).
interface mem_bus_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   // Upstream requester side, one 8/8/64-bit slot per port
   logic [NREQ-1:0]         s_mem_lock;
   logic [NREQ-1:0][7:0]    s_mem_rqst;
   logic [NREQ-1:0][7:0]    s_mem_trsc;
   logic [NREQ-1:0][63:0]   s_mem_addr;
   logic [NREQ-1:0][7:0]    s_mem_resp;
   logic [NREQ-1:0][7:0]    s_mem_mesi;

   // Downstream memory side
   logic                    m_mem_lock;
   logic [7:0]              m_mem_rqst;
   logic [7:0]              m_mem_trsc;
   logic [63:0]             m_mem_addr;
   logic [7:0]              m_mem_resp;
   logic [7:0]              m_mem_mesi;

   // Arbiter status
   logic [NREQ-1:0]         grant;
   logic                    busy;

   // Arbiter view
   modport master (
      input  s_mem_lock, s_mem_rqst, s_mem_trsc, s_mem_addr,
      input  m_mem_resp, m_mem_mesi,
      output s_mem_resp, s_mem_mesi,
      output m_mem_lock, m_mem_rqst, m_mem_trsc, m_mem_addr,
      output grant, busy
   );

   // Environment view (requesters plus downstream slave)
   modport slave (
      output s_mem_lock, s_mem_rqst, s_mem_trsc, s_mem_addr,
      output m_mem_resp, m_mem_mesi,
      input  s_mem_resp, s_mem_mesi,
      input  m_mem_lock, m_mem_rqst, m_mem_trsc, m_mem_addr,
      input  grant, busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one downstream memory port
// between NREQ requesters, one outstanding transaction, with bus locking.
// Optional watchdog on the WAIT state: define ARB_TIMEOUT_EN to enable it
// (TIMEOUT cycles, error response 8'hFF).
module mem_bus_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.master bus
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Reject out-of-range configurations at elaboration
   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("mem_bus_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_TURN = 2'd2
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [IDX_W-1:0]        r_g;
   logic                    r_owner_vld;

   logic                    r_m_lock;
   logic [7:0]              r_m_rqst;
   logic [7:0]              r_m_trsc;
   logic [63:0]             r_m_addr;
   logic [NREQ-1:0][7:0]    r_s_resp;
   logic [NREQ-1:0][7:0]    r_s_mesi;
   logic [NREQ-1:0]         r_grant;
   logic                    r_busy;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]         r_to_cnt;
`endif

   logic [NREQ-1:0]         w_elig;
   logic                    w_found;
   logic [IDX_W-1:0]        w_win;
   logic [IDX_W-1:0]        w_cand;

   // A port is eligible when it has a request; a lock owner excludes all others
   always_comb begin
      w_elig = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_elig[i] = (bus.s_mem_rqst[i] != 8'd0) &&
                     (!r_owner_vld || (r_g == IDX_W'(i)));
      end
   end

   // Round-robin pick: first eligible port after the last winner
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_cand = IDX_W'((32'(r_rr_ptr) + k) % NREQ);
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Arbitration FSM with all bus outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= IDX_W'(NREQ - 1);
         r_g         <= '0;
         r_owner_vld <= 1'b0;
         r_m_lock    <= 1'b0;
         r_m_rqst    <= 8'd0;
         r_m_trsc    <= 8'd0;
         r_m_addr    <= 64'd0;
         r_s_resp    <= '0;
         r_s_mesi    <= '0;
         r_grant     <= '0;
         r_busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_owner_vld && !bus.s_mem_lock[r_g]) begin
                  // Owner released the lock: open arbitration next cycle
                  r_owner_vld <= 1'b0;
                  r_grant     <= '0;
                  r_m_lock    <= 1'b0;
               end else if (w_found) begin
                  r_g      <= w_win;
                  r_rr_ptr <= w_win;
                  r_grant  <= NREQ'(1) << w_win;
                  r_m_rqst <= bus.s_mem_rqst[w_win];
                  r_m_trsc <= bus.s_mem_trsc[w_win];
                  r_m_addr <= bus.s_mem_addr[w_win];
                  r_m_lock <= bus.s_mem_lock[w_win];
                  r_busy   <= 1'b1;
                  r_state  <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end else begin
                  // Idle owner keeps the bus locked; otherwise unlocked
                  r_m_lock <= r_owner_vld;
               end
            end

            S_WAIT: begin
               r_m_lock <= bus.s_mem_lock[r_g];
               if (bus.m_mem_resp != 8'd0) begin
                  r_s_resp[r_g] <= bus.m_mem_resp;
                  r_s_mesi[r_g] <= bus.m_mem_mesi;
                  r_m_rqst      <= 8'd0;
                  r_m_trsc      <= 8'd0;
                  r_m_addr      <= 64'd0;
                  r_owner_vld   <= bus.s_mem_lock[r_g];
                  r_state       <= S_TURN;
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                  // Watchdog: report an error and drop any lock ownership
                  r_s_resp[r_g] <= 8'hFF;
                  r_m_rqst      <= 8'd0;
                  r_m_trsc      <= 8'd0;
                  r_m_addr      <= 64'd0;
                  r_owner_vld   <= 1'b0;
                  r_state       <= S_TURN;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
`endif
            end

            S_TURN: begin
               // Downstream may still echo the old response; ignore it here
               r_s_resp <= '0;
               r_grant  <= r_owner_vld ? r_grant : '0;
               r_m_lock <= r_owner_vld && bus.s_mem_lock[r_g];
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.m_mem_lock = r_m_lock;
   assign bus.m_mem_rqst = r_m_rqst;
   assign bus.m_mem_trsc = r_m_trsc;
   assign bus.m_mem_addr = r_m_addr;
   assign bus.s_mem_resp = r_s_resp;
   assign bus.s_mem_mesi = r_s_mesi;
   assign bus.grant      = r_grant;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NREQ=4, TIMEOUT=8).
module tb_mem_bus_arbiter;

   localparam int unsigned NREQ = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   mem_bus_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Downstream slave: 0 = respond with the request code in the same cycle,
   // 1 = also hold the response one cycle after rqst drops, 2 = silent
   logic [1:0] sl_mode;
   logic [7:0] sl_prev;

   always @(posedge clk) sl_prev <= bus.m_mem_rqst;

   always_comb begin
      bus.m_mem_resp = 8'd0;
      case (sl_mode)
         2'd0:    bus.m_mem_resp = bus.m_mem_rqst;
         2'd1:    bus.m_mem_resp = bus.m_mem_rqst | sl_prev;
         default: bus.m_mem_resp = 8'd0;
      endcase
   end

   assign bus.m_mem_mesi = 8'h01;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int p, input logic [7:0] rq, input logic [7:0] tr,
                          input logic [63:0] ad, input logic lk);
      bus.s_mem_rqst[p] = rq;
      bus.s_mem_trsc[p] = tr;
      bus.s_mem_addr[p] = ad;
      bus.s_mem_lock[p] = lk;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          order [3];
      int          p;
      logic [3:0]  e_grant;
      logic [31:0] e_resp;

      order = '{0, 1, 3};
      rst = 1'b1;
      sl_mode = 2'd0;
      bus.s_mem_lock = '0;
      bus.s_mem_rqst = '0;
      bus.s_mem_trsc = '0;
      bus.s_mem_addr = '0;
      tick();
      tick();

      // Reset state
      chk("rst_grant", 64'(bus.grant), 64'h0);
      chk("rst_busy",  64'(bus.busy), 64'h0);
      chk("rst_rqst",  64'(bus.m_mem_rqst), 64'h0);
      chk("rst_lock",  64'(bus.m_mem_lock), 64'h0);
      chk("rst_resp",  64'(bus.s_mem_resp), 64'h0);
      chk("rst_mesi",  64'(bus.s_mem_mesi), 64'h0);

      // Single request from port 2
      rst = 1'b0;
      set_req(2, 8'h03, 8'h11, 64'h1000, 1'b0);
      tick();
      chk("single_grant", 64'(bus.grant), 64'h4);
      chk("single_rqst",  64'(bus.m_mem_rqst), 64'h03);
      chk("single_trsc",  64'(bus.m_mem_trsc), 64'h11);
      chk("single_addr",  bus.m_mem_addr, 64'h1000);
      chk("single_busy",  64'(bus.busy), 64'h1);
      chk("single_noresp", 64'(bus.s_mem_resp), 64'h0);
      tick();
      chk("single_resp",  64'(bus.s_mem_resp), 64'h0003_0000);
      chk("single_mesi",  64'(bus.s_mem_mesi), 64'h0001_0000);
      chk("single_turn_grant", 64'(bus.grant), 64'h4);
      chk("single_turn_rqst",  64'(bus.m_mem_rqst), 64'h0);
      chk("single_turn_addr",  bus.m_mem_addr, 64'h0);
      set_req(2, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();
      chk("single_resp_clr", 64'(bus.s_mem_resp), 64'h0);
      chk("single_mesi_hold", 64'(bus.s_mem_mesi), 64'h0001_0000);
      chk("single_idle_grant", 64'(bus.grant), 64'h0);
      chk("single_idle_busy", 64'(bus.busy), 64'h0);
      tick();
      chk("single_idle_rqst", 64'(bus.m_mem_rqst), 64'h0);

      // Round-robin: ports 0,1,3 request continuously from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 8'h01, 8'hA0, 64'h100, 1'b0);
      set_req(1, 8'h02, 8'hA1, 64'h200, 1'b0);
      set_req(3, 8'h04, 8'hA3, 64'h400, 1'b0);
      for (int k = 0; k < 6; k++) begin
         p = order[k % 3];
         e_grant = 4'b0001 << p;
         e_resp  = 32'(p + 1) << (8 * p);
         tick();
         chk("rr_grant", 64'(bus.grant), 64'(e_grant));
         chk("rr_rqst",  64'(bus.m_mem_rqst), 64'(p + 1));
         tick();
         chk("rr_resp",  64'(bus.s_mem_resp), 64'(e_resp));
         tick();
         chk("rr_gap_grant", 64'(bus.grant), 64'h0);
      end
      bus.s_mem_rqst = '0;
      tick();
      chk("rr_quiet", 64'(bus.busy), 64'h0);

      // Lock: port 1 holds the bus over two requests while port 0 waits
      set_req(1, 8'h05, 8'hB0, 64'h500, 1'b1);
      tick();
      chk("lk_grant1", 64'(bus.grant), 64'h2);
      chk("lk_rqst1",  64'(bus.m_mem_rqst), 64'h05);
      chk("lk_lock1",  64'(bus.m_mem_lock), 64'h1);
      set_req(0, 8'h01, 8'hB1, 64'h600, 1'b0);
      tick();
      chk("lk_resp1",  64'(bus.s_mem_resp), 64'h0000_0500);
      chk("lk_lock_turn", 64'(bus.m_mem_lock), 64'h1);
      set_req(1, 8'h06, 8'hB2, 64'h508, 1'b1);
      tick();
      chk("lk_idle_grant", 64'(bus.grant), 64'h2);
      chk("lk_idle_lock",  64'(bus.m_mem_lock), 64'h1);
      chk("lk_idle_busy",  64'(bus.busy), 64'h0);
      tick();
      chk("lk_grant2", 64'(bus.grant), 64'h2);
      chk("lk_rqst2",  64'(bus.m_mem_rqst), 64'h06);
      chk("lk_lock2",  64'(bus.m_mem_lock), 64'h1);
      tick();
      chk("lk_resp2",  64'(bus.s_mem_resp), 64'h0000_0600);
      set_req(1, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();
      chk("lk_hold_grant", 64'(bus.grant), 64'h2);
      chk("lk_hold_rqst",  64'(bus.m_mem_rqst), 64'h0);
      tick();
      chk("lk_release_grant", 64'(bus.grant), 64'h0);
      chk("lk_release_lock",  64'(bus.m_mem_lock), 64'h0);
      tick();
      chk("lk_p0_grant", 64'(bus.grant), 64'h1);
      chk("lk_p0_rqst",  64'(bus.m_mem_rqst), 64'h01);
      chk("lk_p0_lock",  64'(bus.m_mem_lock), 64'h0);
      tick();
      chk("lk_p0_resp",  64'(bus.s_mem_resp), 64'h0000_0001);
      set_req(0, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();

      // Turnaround echo: slave holds resp one extra cycle
      sl_mode = 2'd1;
      set_req(2, 8'h03, 8'hC2, 64'h700, 1'b0);
      tick();
      chk("echo_grant", 64'(bus.grant), 64'h4);
      tick();
      chk("echo_resp", 64'(bus.s_mem_resp), 64'h0003_0000);
      set_req(2, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();
      chk("echo_no_pulse", 64'(bus.s_mem_resp), 64'h0);
      chk("echo_no_grant", 64'(bus.grant), 64'h0);
      chk("echo_not_busy", 64'(bus.busy), 64'h0);
      tick();
      chk("echo_still_idle", 64'(bus.grant), 64'h0);
      chk("echo_still_rqst", 64'(bus.m_mem_rqst), 64'h0);
      chk("echo_still_resp", 64'(bus.s_mem_resp), 64'h0);
      sl_mode = 2'd0;

      // Reset in the middle of WAIT
      sl_mode = 2'd2;
      set_req(2, 8'h07, 8'h22, 64'h2000, 1'b0);
      tick();
      chk("rw_grant", 64'(bus.grant), 64'h4);
      chk("rw_trsc",  64'(bus.m_mem_trsc), 64'h22);
      tick();
      chk("rw_wait_busy", 64'(bus.busy), 64'h1);
      chk("rw_wait_rqst", 64'(bus.m_mem_rqst), 64'h07);
      chk("rw_wait_resp", 64'(bus.s_mem_resp), 64'h0);
      rst = 1'b1;
      tick();
      chk("rw_rst_grant", 64'(bus.grant), 64'h0);
      chk("rw_rst_rqst",  64'(bus.m_mem_rqst), 64'h0);
      chk("rw_rst_addr",  bus.m_mem_addr, 64'h0);
      chk("rw_rst_busy",  64'(bus.busy), 64'h0);
      chk("rw_rst_resp",  64'(bus.s_mem_resp), 64'h0);
      chk("rw_rst_mesi",  64'(bus.s_mem_mesi), 64'h0);
      rst = 1'b0;
      sl_mode = 2'd0;
      tick();
      chk("rw_regrant", 64'(bus.grant), 64'h4);
      chk("rw_regrant_rqst", 64'(bus.m_mem_rqst), 64'h07);
      tick();
      chk("rw_resp", 64'(bus.s_mem_resp), 64'h0007_0000);
      chk("rw_mesi", 64'(bus.s_mem_mesi), 64'h0001_0000);
      set_req(2, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();

`ifdef ARB_TIMEOUT_EN
      // Watchdog: silent slave, port 3 times out, then port 1 served
      sl_mode = 2'd2;
      set_req(1, 8'h09, 8'hD1, 64'h900, 1'b0);
      set_req(3, 8'h0A, 8'hD3, 64'hA00, 1'b0);
      tick();
      chk("to_grant", 64'(bus.grant), 64'h8);
      chk("to_rqst",  64'(bus.m_mem_rqst), 64'h0A);
      repeat (7) tick();
      chk("to_wait_resp", 64'(bus.s_mem_resp), 64'h0);
      chk("to_wait_busy", 64'(bus.busy), 64'h1);
      chk("to_wait_rqst", 64'(bus.m_mem_rqst), 64'h0A);
      tick();
      chk("to_resp", 64'(bus.s_mem_resp), 64'hFF00_0000);
      chk("to_rqst_clr", 64'(bus.m_mem_rqst), 64'h0);
      chk("to_mesi_hold", 64'(bus.s_mem_mesi), 64'h0001_0000);
      set_req(3, 8'h00, 8'h00, 64'h0, 1'b0);
      sl_mode = 2'd0;
      tick();
      chk("to_idle_resp", 64'(bus.s_mem_resp), 64'h0);
      tick();
      chk("to_next_grant", 64'(bus.grant), 64'h2);
      chk("to_next_rqst",  64'(bus.m_mem_rqst), 64'h09);
      tick();
      chk("to_next_resp", 64'(bus.s_mem_resp), 64'h0000_0900);
      set_req(1, 8'h00, 8'h00, 64'h0, 1'b0);
      tick();
`else
      // Without the watchdog a silent slave keeps the arbiter in WAIT
      sl_mode = 2'd2;
      set_req(3, 8'h0A, 8'hD3, 64'hA00, 1'b0);
      tick();
      chk("nto_grant", 64'(bus.grant), 64'h8);
      repeat (20) tick();
      chk("nto_busy", 64'(bus.busy), 64'h1);
      chk("nto_rqst", 64'(bus.m_mem_rqst), 64'h0A);
      chk("nto_resp", 64'(bus.s_mem_resp), 64'h0);
      set_req(3, 8'h00, 8'h00, 64'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sl_mode = 2'd0;
      tick();
      chk("nto_after_rst", 64'(bus.grant), 64'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
